// File: rtl/lock_code_sender.sv
// lock_code_sender: clocks a fixed unlock sequence into a combination lock.
// Each attempt strobes FLUSH, W0, W1, W2 and then watches the lock's ack
// for a short window. The block makes up to three attempts and then
// reports either DONE (ok=1) or FAIL (code=5'b11111).
// io_in : [7:6] hold select, [5] abort, [4] ack, [3] start, [2] clk,
//         [1] rst_n, [0] unused.
// io_out: [7] ok, [6] busy, [5] lk_clk, [4:0] code.
module lock_code_sender (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam logic [4:0] WORD_FLUSH = 5'b00000;
  localparam logic [4:0] WORD_0     = 5'b10000;
  localparam logic [4:0] WORD_1     = 5'b01100;
  localparam logic [4:0] WORD_2     = 5'b11101;
  localparam logic [2:0] WIN_LAST   = 3'd5;
  localparam logic [1:0] LAST_TRY   = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ack;
  logic       abort;
  logic [1:0] hold_sel;
  logic       unused_in;

  assign unused_in = io_in[0];
  assign rst_n     = io_in[1];
  assign clk       = io_in[2];
  assign start     = io_in[3];
  assign ack       = io_in[4];
  assign abort     = io_in[5];
  assign hold_sel  = io_in[7:6];

  // state is kept as a named internal signal so checkers can bind to it
  state_t     state;
  state_t     state_nxt;

  logic       start_r;
  logic       start_prev;
  logic       seen_low;
  logic       ack_meta;
  logic       ack_sync;
  logic [1:0] n_sel;
  logic [4:0] hold_cnt;
  logic [1:0] word_idx;
  logic [2:0] win_cnt;
  logic [1:0] attempt;

  logic [4:0] hold_n;
  logic [4:0] half_n;
  logic       word_end;
  logic       win_end;
  logic       start_edge;
  logic       do_abort;
  logic [4:0] word;
  logic [4:0] code;
  logic       lk_clk;
  logic       busy;
  logic       ok;

  // N = 2, 4, 8 or 16 cycles per word, taken from the value latched at start
  assign hold_n   = 5'd2 << n_sel;
  assign half_n   = {1'b0, hold_n[4:1]};
  assign word_end = (hold_cnt == (hold_n - 5'd1));
  assign win_end  = (win_cnt == WIN_LAST);
  // seen_low keeps a start held high through reset from counting as an edge
  assign start_edge = start_r & ~start_prev & seen_low;
  assign do_abort   = abort & (state != IDLE);

  // start edge detector and two-flop ack synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r    <= 1'b0;
      start_prev <= 1'b0;
      seen_low   <= 1'b0;
      ack_meta   <= 1'b0;
      ack_sync   <= 1'b0;
    end else begin
      start_r    <= start;
      start_prev <= start_r;
      seen_low   <= seen_low | ~start;
      ack_meta   <= ack;
      ack_sync   <= ack_meta;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; abort outranks everything, including a start edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAIL: if (start_edge) state_nxt = SEND;
      SEND:  if (word_end && (word_idx == 2'd3)) state_nxt = CHECK;
      CHECK: begin
        if (ack_sync) state_nxt = DONE;
        else if (win_end) state_nxt = (attempt == LAST_TRY) ? FAIL : SEND;
      end
      default: state_nxt = IDLE;
    endcase
    if (do_abort) state_nxt = IDLE;
  end

  // hold, word, window and attempt counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_sel    <= 2'd0;
      hold_cnt <= 5'd0;
      word_idx <= 2'd0;
      win_cnt  <= 3'd0;
      attempt  <= 2'd0;
    end else if (do_abort) begin
      n_sel    <= 2'd0;
      hold_cnt <= 5'd0;
      word_idx <= 2'd0;
      win_cnt  <= 3'd0;
      attempt  <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start_edge) begin
            n_sel    <= hold_sel;
            hold_cnt <= 5'd0;
            word_idx <= 2'd0;
            win_cnt  <= 3'd0;
            attempt  <= 2'd0;
          end
        end
        SEND: begin
          win_cnt <= 3'd0;
          if (word_end) begin
            hold_cnt <= 5'd0;
            // W2 -> index 0 wraps naturally, ready for a retry
            word_idx <= word_idx + 2'd1;
          end else begin
            hold_cnt <= hold_cnt + 5'd1;
          end
        end
        CHECK: begin
          if (win_end && !ack_sync) begin
            win_cnt <= 3'd0;
            if (attempt != LAST_TRY) attempt <= attempt + 2'd1;
          end else begin
            win_cnt <= win_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // constant word table
  always_comb begin
    word = WORD_FLUSH;
    case (word_idx)
      2'd1:    word = WORD_0;
      2'd2:    word = WORD_1;
      2'd3:    word = WORD_2;
      default: word = WORD_FLUSH;
    endcase
  end

  // Moore outputs; lk_clk rises half-way through each word
  always_comb begin
    code   = 5'd0;
    lk_clk = 1'b0;
    busy   = 1'b0;
    ok     = 1'b0;
    case (state)
      SEND: begin
        code   = word;
        lk_clk = (hold_cnt >= half_n);
        busy   = 1'b1;
      end
      CHECK:   busy = 1'b1;
      DONE:    ok = 1'b1;
      FAIL:    code = 5'b11111;
      default: ;
    endcase
  end

  assign io_out = {ok, busy, lk_clk, code};

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender. The monitor turns io_out into runs of
// {value, length in cycles}; each scenario pushes its expected runs first
// (length 0 = any length) and the monitor pops one per completed run.
module tb_lock_code_sender;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       start    = 1'b0;
  logic       abort    = 1'b0;
  logic       ack_en   = 1'b0;
  logic       ack_lock = 1'b0;
  logic       noise    = 1'b0;
  logic [1:0] sel      = 2'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  assign io_in = {sel, abort, ack_en & ack_lock, start, clk, rst_n, noise};

  lock_code_sender dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  // clock / ignored input bit
  always #5 clk = ~clk;
  always @(posedge clk) noise <= 1'($urandom_range(0, 1));

  // lock model: opens when its last three strobed codes are W0, W1, W2
  logic [4:0] h0 = 5'd0, h1 = 5'd0, h2 = 5'd0;
  int strobe_cnt = 0;
  always @(posedge io_out[5]) begin
    h0 = h1;
    h1 = h2;
    h2 = io_out[4:0];
    strobe_cnt++;
    #3 ack_lock = (h0 == 5'h10) && (h1 == 5'h0C) && (h2 == 5'h1D);
  end

  // monitor: emits a run whenever io_out changes value
  logic [7:0] prev_val = 8'h00;
  int run_len = 0;

  task automatic close_run(input logic [7:0] v, input int len);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_run: got %02h for %0d cycles, required no change", v, len);
    end else begin
      e = exp_q.pop_front();
      if (v !== e[15:8] || (e[7:0] != 8'd0 && len != int'(e[7:0]))) begin
        errors++;
        $display("FAIL run: got %02h for %0d cycles, required %02h for %0d cycles (0=any)",
                 v, len, e[15:8], e[7:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (io_out === prev_val) begin
      if (run_len < 255) run_len++;
    end else begin
      close_run(prev_val, run_len);
      prev_val = io_out;
      run_len  = 1;
    end
  end

  // driver / scoreboard helpers
  function automatic void push(input logic [7:0] v, input int len);
    exp_q.push_back({v, 8'(len)});
  endfunction

  // one attempt: 8 half-words; lead = CHECK cycles merged into FLUSH's 0x40 run
  task automatic push_send(input int half, input int lead);
    push(8'h40, lead + half); push(8'h60, half);
    push(8'h50, half);        push(8'h70, half);
    push(8'h4C, half);        push(8'h6C, half);
    push(8'h5D, half);        push(8'h7D, half);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic wait_q(input int target, input int budget, input string name);
    int n = 0;
    while (exp_q.size() > target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_q.size() > target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: queue depth %0d, required %0d", name, exp_q.size(), target);
      exp_q.delete();
    end
  endtask

  task automatic wait_out(input logic [7:0] v, input int budget);
    int n = 0;
    while (io_out !== v && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_abort(input string name);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    wait_q(0, 20, name);
    check8(name, io_out, 8'h00);
  endtask

  initial begin
    int n;
    // reset
    #1 rst_n = 1'b0;
    #1 check8("reset_out", io_out, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=2, lock connected: one attempt then DONE
    sel = 2'b00; ack_en = 1'b1;
    push(8'h00, 0); push_send(1, 0); push(8'h40, 2); push(8'h80, 0);
    pulse_start();
    wait_q(1, 200, "n2_unlock");
    check8("n2_done", io_out, 8'h80);
    do_abort("n2_abort");

    // N=4, ack held 0: three attempts then FAIL
    sel = 2'b01; ack_en = 1'b0;
    push(8'h00, 0); push_send(2, 0); push_send(2, 6); push_send(2, 6);
    push(8'h40, 6); push(8'h1F, 0);
    pulse_start();
    wait_q(1, 300, "n4_fail");
    check8("n4_fail_out", io_out, 8'h1F);
    do_abort("n4_abort");

    // N=8, abort during W1, then a fresh run
    sel = 2'b10; ack_en = 1'b0;
    push(8'h00, 0); push(8'h40, 4); push(8'h60, 4); push(8'h50, 4); push(8'h70, 4);
    push(8'h4C, 1);
    pulse_start();
    wait_out(8'h4C, 100);
    abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    check8("w1_abort_out", io_out, 8'h00);
    wait_q(0, 20, "w1_abort");
    ack_en = 1'b1;
    push(8'h00, 0); push_send(4, 0); push(8'h40, 1); push(8'h80, 0);
    pulse_start();
    wait_q(1, 200, "rerun");
    check8("rerun_done", io_out, 8'h80);
    do_abort("rerun_abort");

    // N=2, reset mid-CHECK; start held high through release
    sel = 2'b00; ack_en = 1'b0;
    push(8'h00, 0); push_send(1, 0); push(8'h40, 1);
    pulse_start();
    wait_out(8'h7D, 50);
    wait_out(8'h40, 10);
    #5 rst_n = 1'b0;
    #1 check8("async_reset", io_out, 8'h00);
    start = 1'b1;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    wait_q(0, 20, "reset_run");
    repeat (20) @(posedge clk);
    #2 check8("start_held", io_out, 8'h00);
    ack_en = 1'b1;
    push(8'h00, 0); push_send(1, 0); push(8'h40, 2); push(8'h80, 0);
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_q(1, 200, "restart");
    check8("restart_done", io_out, 8'h80);
    do_abort("restart_abort");

    // N=2, ack enabled only from the second attempt
    sel = 2'b00; ack_en = 1'b0; strobe_cnt = 0;
    push(8'h00, 0); push_send(1, 0); push_send(1, 6); push(8'h40, 2); push(8'h80, 0);
    pulse_start();
    n = 0;
    while (strobe_cnt < 5 && n < 100) begin
      @(posedge clk); #5;
      n++;
    end
    ack_en = 1'b1;
    wait_q(1, 200, "second_try");
    check8("second_try_done", io_out, 8'h80);
    do_abort("second_try_abort");

    // N=16, hold select changed to 00 while busy
    sel = 2'b11; ack_en = 1'b1;
    push(8'h00, 0); push_send(8, 0); push(8'h40, 1); push(8'h80, 0);
    pulse_start();
    repeat (4) @(negedge clk);
    sel = 2'(0 * $urandom_range(0, 1));
    wait_q(1, 300, "sel_change");
    check8("sel_change_done", io_out, 8'h80);
    do_abort("sel_change_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_code_sender.md
LOCK_CODE_SENDER -- requirements
Module: lock_code_sender

Interface
REQ-001 SHALL expose exactly two ports: io_in (input, 8 bits) and io_out (output, 8 bits); fields listed below, clock and reset first.
REQ-002 io_in[2]  input  1  clk, the single clock; all state changes on its rising edge.
REQ-003 io_in[1]  input  1  rst_n; reset is asynchronous and active-low.
REQ-004 io_in[3]  input  1  start; the block acts on its rising edge.
REQ-005 io_in[4]  input  1  ack, the lock's unlock indication; asynchronous to clk.
REQ-006 io_in[5]  input  1  abort, level-sensitive.
REQ-007 io_in[7:6]  input  2  hold select: 00=2, 01=4, 10=8, 11=16 cycles per word.
REQ-008 io_in[0]  input  1  unused; SHALL be ignored.
REQ-009 io_out[4:0]  output  5  code[4:0], driven to the lock's code inputs (bit0 is the lock's first code input).
REQ-010 io_out[5]  output  1  lk_clk, the strobe that clocks the lock.
REQ-011 io_out[6]  output  1  busy.
REQ-012 io_out[7]  output  1  ok, set on confirmed unlock.

Function
REQ-013 SHALL hold the constant words FLUSH=5'b00000, W0=5'b10000, W1=5'b01100 and W2=5'b11101.
REQ-014 SHALL implement states IDLE, SEND, CHECK, DONE and FAIL.
REQ-015 start edge detect: start is registered, and an edge is start=1 with prev=0; edges outside IDLE/DONE/FAIL SHALL be ignored.
REQ-016 On an accepted edge, SHALL latch hold select as N, set attempt=0, clear ok and go to SEND at word index 0; busy=1 from the next cycle.
REQ-017 SEND SHALL drive words in the order FLUSH, W0, W1, W2, each for exactly N cycles.
REQ-018 lk_clk SHALL be 1 during the last N/2 cycles of each word and 0 otherwise, so code is stable N/2 cycles on both sides of each lk_clk rising edge.
REQ-019 After the last cycle of W2, SHALL enter CHECK with code=0 and lk_clk=0.
REQ-020 ack SHALL pass a 2-flop synchronizer; CHECK SHALL sample the synchronized ack for a window of 6 cycles.
REQ-021 If the synchronized ack is 1 in any window cycle, the next state SHALL be DONE: ok=1, busy=0, code=0, held until the next accepted start or abort.
REQ-022 If the window expires with attempt<2, SHALL increment attempt and restart SEND at FLUSH; 3 attempts total.
REQ-023 If the window expires with attempt==2, the next state SHALL be FAIL: busy=0, ok=0, code=5'b11111, lk_clk=0, held until the next start or abort.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE on the next edge: all outputs 0 and all counters cleared; abort in IDLE has no effect.
REQ-025 abort SHALL win over a simultaneous start edge.
REQ-026 Changes to io_in[7:6] while busy SHALL have no effect until the next accepted start.
REQ-027 Hold counter SHALL be 5 bits wide, counting 0..N-1 and wrapping to 0 at each word boundary; no other wrap is permitted.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, with io_out=8'h00, all counters 0 and synchronizer/edge registers 0, including mid-SEND or mid-CHECK.
REQ-029 After rst_n deasserts, a start held high SHALL NOT register as an edge until it has been seen low.

Verification
REQ-030 Bench SHALL cover the following scenarios:
- N=2, start pulse, ack tied to a lock model: code sequence 00,10,0C,1D for 2 cycles each; lk_clk high on cycles 2,4,6,8 after busy rises; ok=1 within 6 cycles of the final strobe plus 2 sync cycles; busy=0.
- ack held 0, N=4: three full attempts of 16 cycles each plus 6-cycle windows; then FAIL with code=1F, ok=0, busy=0.
- abort asserted during W1 with N=8: the next cycle gives io_out=00 and IDLE; a following start runs a fresh attempt 0.
- rst_n pulsed low mid-CHECK: io_out=00 asynchronously; start held high after release gives no activity until start toggles low then high.
- ack arrives on the 2nd attempt: exactly one FLUSH precedes the second W0, and DONE follows with ok=1.
- Hold select changed 11->00 while busy: word length stays 16 cycles throughout the run.
